id_operand_fetch: RTL and testbench
===================================

ID_OPERAND_FETCH -- requirements
Module: id_operand_fetch

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of opaque decoded control bundle passed to execute.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in_valid input 1 / in_ready output 1  decode-side handshake.
REQ-005 SHALL have ports in_rs1, in_rs2, in_rd  input  5 each  source and destination register addresses.
REQ-006 SHALL have ports in_rd_we input 1 (instruction writes rd), in_ctrl input CTRL_W (control bundle).
REQ-007 SHALL have ports reg_read_des_addr_1, reg_read_des_addr_2  output  5  register file read addresses.
REQ-008 SHALL have ports read_reg_data_1, read_reg_data_2  input  32  register file combinational read data.
REQ-009 SHALL have ports wb_en input 1, wb_addr input 5, wb_data input 32  writeback snoop, same values driven to register file write port.
REQ-010 SHALL have ports ex_valid output 1 / ex_ready input 1  execute-side handshake.
REQ-011 SHALL have ports ex_op_a, ex_op_b output 32, ex_rd output 5, ex_rd_we output 1, ex_ctrl output CTRL_W.

Function
REQ-012 SHALL drive reg_read_des_addr_1/2 combinationally from in_rs1/in_rs2.
REQ-013 SHALL keep a 32-bit scoreboard; bit n set = write to register n in flight; bit 0 always 0.
REQ-014 SHALL declare hazard when in_rs1 or in_rs2 (nonzero) is busy and not bypassable, or when in_rd_we and in_rd (nonzero) is busy (WAW).
REQ-015 SHALL drive in_ready = (!ex_valid || ex_ready) && !hazard; transfer on in_valid && in_ready.
REQ-016 SHALL, on transfer, register operands, rd, rd_we, ctrl and set ex_valid next cycle; latency exactly 1 cycle.
REQ-017 SHALL hold all ex_* outputs stable while ex_valid && !ex_ready.
REQ-018 SHALL clear ex_valid after ex_valid && ex_ready with no new transfer in that cycle.
REQ-019 SHALL force operand to 32'd0 when its source address is 0, irrespective of read data or bypass.
REQ-020 SHALL set scoreboard bit in_rd on transfer with in_rd_we and in_rd != 0.
REQ-021 SHALL clear scoreboard bit wb_addr when wb_en; set of same bit in same cycle wins.
REQ-022 SHALL ignore wb_en for a register whose bit is clear (no error, no state change).

Reset
REQ-023 SHALL, on rst high at a clock edge, clear scoreboard, ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_we, ex_ctrl to zero, discarding any held instruction.
REQ-024 SHALL drive in_ready 0 during the cycle rst is high; rst dominates every simultaneous transfer or writeback.

Configuration
REQ-025 SHALL support macro ID_WB_BYPASS_EN.
REQ-026 SHALL, with ID_WB_BYPASS_EN defined, treat a busy source as bypassable when wb_en && wb_addr == source, selecting wb_data as operand.
REQ-027 SHALL, without ID_WB_BYPASS_EN, never bypass; such a source stalls one cycle and is read from the register file after write.

Structure
REQ-028 SHALL take XLEN (32), REG_ADDR_W (5) and NUM_REGS (32) from shared package cpu_pkg.
REQ-029 SHALL implement scoreboard as sub-module reg_scoreboard (set port, clear port, busy vector).

Verification
REQ-030 SHALL cover: reset then in_rs1=3 (x3=0x11), in_rs2=4 (x4=0x22), ex_ready=1 -> next cycle ex_op_a=0x11, ex_op_b=0x22, ex_valid=1.
REQ-031 SHALL cover: issue rd=5 then rs1=5 with no wb -> in_ready=0 until wb_en, wb_addr=5, wb_data=0xABCD; with macro same cycle accept, ex_op_a=0xABCD; without, one cycle later.
REQ-032 SHALL cover: rs1=0 with wb_en, wb_addr=0, wb_data=0xFFFF_FFFF -> ex_op_a=0, bit 0 never set.
REQ-033 SHALL cover: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, in_ready=0.
REQ-034 SHALL cover: issue rd=7 in same cycle as wb_en, wb_addr=7 -> bit 7 remains set; rd=7 WAW issue stalls.
REQ-035 SHALL cover: rst asserted with ex_valid=1 and bits 2,9 busy -> next cycle ex_valid=0, scoreboard all zero.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU core types and sizes used by the decode/operand-fetch slice.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // x0 is hardwired to zero, so many paths treat address 0 specially.
    function automatic logic addr_nz(input reg_addr_t a);
        return a != '0;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: one bit per architectural register marks an
// outstanding write. A set and a clear of the same bit in one cycle resolve
// to set (the new writer is the one still in flight). Bit 0 never sets.
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en_i,
    input  reg_addr_t           set_addr_i,
    input  logic                clr_en_i,
    input  reg_addr_t           clr_addr_i,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
        if (gi == 0) begin : g_zero
            assign busy_d[gi] = 1'b0;
        end else begin : g_reg
            assign busy_d[gi] = (set_en_i && set_addr_i == REG_ADDR_W'(gi)) ? 1'b1 :
                                (clr_en_i && clr_addr_i == REG_ADDR_W'(gi)) ? 1'b0 :
                                busy_q[gi];
        end
    end

    // Busy vector state; reset drops every outstanding write.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-to-execute operand fetch stage. Reads two sources from the register
// file, stalls on RAW/WAW hazards tracked by a scoreboard, and presents a
// single registered instruction slot to execute.
// Optional feature: define ID_WB_BYPASS_EN to forward same-cycle writeback
// data into a busy source instead of stalling.
module id_operand_fetch
    import cpu_pkg::*;
#(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        reg_read_des_addr_1,
    output logic [4:0]        reg_read_des_addr_2,
    input  logic [31:0]       read_reg_data_1,
    input  logic [31:0]       read_reg_data_2,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [31:0]       wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [31:0]       ex_op_a,
    output logic [31:0]       ex_op_b,
    output logic [4:0]        ex_rd,
    output logic              ex_rd_we,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic [NUM_REGS-1:0]   busy;
    reg_addr_t [1:0]       src_addr;
    word_t     [1:0]       src_data;
    logic      [1:0]       src_byp;
    logic      [1:0]       src_haz;
    word_t     [1:0]       op_d;
    logic                  waw_haz;
    logic                  hazard;
    logic                  xfer;
    logic                  sb_set;

    logic                  ex_valid_q;
    word_t                 ex_op_a_q;
    word_t                 ex_op_b_q;
    reg_addr_t             ex_rd_q;
    logic                  ex_rd_we_q;
    logic [CTRL_W-1:0]     ex_ctrl_q;

    assign reg_read_des_addr_1 = in_rs1;
    assign reg_read_des_addr_2 = in_rs2;

    // Index 0 is rs1 / operand A, index 1 is rs2 / operand B.
    assign src_addr = {in_rs2, in_rs1};
    assign src_data = {read_reg_data_2, read_reg_data_1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
`ifdef ID_WB_BYPASS_EN
        assign src_byp[gi] = wb_en && (wb_addr == src_addr[gi]);
`else
        assign src_byp[gi] = 1'b0;
`endif
        assign src_haz[gi] = addr_nz(src_addr[gi]) && busy[src_addr[gi]] && !src_byp[gi];
        // x0 reads zero no matter what the file or the bypass offers.
        assign op_d[gi]    = !addr_nz(src_addr[gi]) ? '0 :
                             (src_byp[gi] && busy[src_addr[gi]]) ? wb_data :
                             src_data[gi];
    end

    // A second writer to a busy rd waits; writeback order must stay intact.
    assign waw_haz  = in_rd_we && addr_nz(in_rd) && busy[in_rd];
    assign hazard   = (|src_haz) || waw_haz;
    assign in_ready = !rst && (!ex_valid_q || ex_ready) && !hazard;
    assign xfer     = in_valid && in_ready;
    assign sb_set   = xfer && in_rd_we && addr_nz(in_rd);

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (sb_set),
        .set_addr_i (in_rd),
        .clr_en_i   (wb_en),
        .clr_addr_i (wb_addr),
        .busy_o     (busy)
    );

    // Execute slot: load on transfer, drop valid once consumed, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_op_a_q  <= '0;
            ex_op_b_q  <= '0;
            ex_rd_q    <= '0;
            ex_rd_we_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else if (xfer) begin
            ex_valid_q <= 1'b1;
            ex_op_a_q  <= op_d[0];
            ex_op_b_q  <= op_d[1];
            ex_rd_q    <= in_rd;
            ex_rd_we_q <= in_rd_we;
            ex_ctrl_q  <= in_ctrl;
        end else if (ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op_a  = ex_op_a_q;
    assign ex_op_b  = ex_op_b_q;
    assign ex_rd    = ex_rd_q;
    assign ex_rd_we = ex_rd_we_q;
    assign ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: a reference model of the scoreboard and the
// execute slot pushes expected bundles on accepted transfers and pops them
// as execute consumes them; directed scenarios plus a short random phase.
module tb_id_operand_fetch;
    import cpu_pkg::*;

    localparam int CTRL_W = 16;
    localparam int BW     = 32 + 32 + 5 + 1 + CTRL_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_rd_we;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        reg_read_des_addr_1, reg_read_des_addr_2;
    logic [31:0]       read_reg_data_1, read_reg_data_2;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;
    logic              ex_valid;
    logic              ex_ready;
    logic [31:0]       ex_op_a, ex_op_b;
    logic [4:0]        ex_rd;
    logic              ex_rd_we;
    logic [CTRL_W-1:0] ex_ctrl;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    // Reference model state
    logic [31:0]   m_sb = '0;
    logic          m_valid = 1'b0;
    logic [BW-1:0] exp_q[$];

    // Register file model, x0 deliberately holds garbage.
    logic [31:0] regs [32];

    always #5 clk = ~clk;

    id_operand_fetch #(.CTRL_W(CTRL_W)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_rs1              (in_rs1),
        .in_rs2              (in_rs2),
        .in_rd               (in_rd),
        .in_rd_we            (in_rd_we),
        .in_ctrl             (in_ctrl),
        .reg_read_des_addr_1 (reg_read_des_addr_1),
        .reg_read_des_addr_2 (reg_read_des_addr_2),
        .read_reg_data_1     (read_reg_data_1),
        .read_reg_data_2     (read_reg_data_2),
        .wb_en               (wb_en),
        .wb_addr             (wb_addr),
        .wb_data             (wb_data),
        .ex_valid            (ex_valid),
        .ex_ready            (ex_ready),
        .ex_op_a             (ex_op_a),
        .ex_op_b             (ex_op_b),
        .ex_rd               (ex_rd),
        .ex_rd_we            (ex_rd_we),
        .ex_ctrl             (ex_ctrl)
    );

    assign read_reg_data_1 = regs[reg_read_des_addr_1];
    assign read_reg_data_2 = regs[reg_read_des_addr_2];

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'hDEAD_BEEF;
        if (i == 3) return 32'h0000_0011;
        if (i == 4) return 32'h0000_0022;
        return 32'h1000_0000 | (i * 32'h101);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
        end else if (wb_en && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_byp(input logic [4:0] a);
`ifdef ID_WB_BYPASS_EN
        return wb_en && (wb_addr == a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_src_haz(input logic [4:0] a);
        return (a != 5'd0) && m_sb[a] && !m_byp(a);
    endfunction

    function automatic logic [31:0] m_op(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_sb[a] && m_byp(a)) return wb_data;
        return regs[a];
    endfunction

    // Mid-cycle monitor: inputs are stable here until the next rising edge.
    always @(negedge clk) begin
        logic exp_rdy;
        logic haz;
        logic xfer;
        if (mon_en) begin
            haz = m_src_haz(in_rs1) || m_src_haz(in_rs2) ||
                  (in_rd_we && in_rd != 5'd0 && m_sb[in_rd]);
            exp_rdy = !rst && (!m_valid || ex_ready) && !haz;
            check("in_ready", in_ready, exp_rdy);
            check("rd_addr", {reg_read_des_addr_1, reg_read_des_addr_2}, {in_rs1, in_rs2});
            check("sb_busy", u_dut.u_sb.busy_o, m_sb);
            check("ex_valid", ex_valid, m_valid);
            if (m_valid) begin
                if (exp_q.size() == 0) check("q_underflow", 1, 0);
                else check("ex_bundle", {ex_op_a, ex_op_b, ex_rd, ex_rd_we, ex_ctrl}, exp_q[0]);
            end
            if (rst) begin
                m_sb    = '0;
                m_valid = 1'b0;
                exp_q.delete();
            end else begin
                xfer = in_valid && exp_rdy;
                if (m_valid && ex_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (xfer) begin
                    exp_q.push_back({m_op(in_rs1), m_op(in_rs2), in_rd, in_rd_we, in_ctrl});
                    $display("xfer rs1=%0d rs2=%0d rd=%0d we=%0d ctrl=%h opa=%h opb=%h",
                             in_rs1, in_rs2, in_rd, in_rd_we, in_ctrl, m_op(in_rs1), m_op(in_rs2));
                end
                m_valid = xfer || (m_valid && !ex_ready);
                if (wb_en) m_sb[wb_addr] = 1'b0;
                if (xfer && in_rd_we && in_rd != 5'd0) m_sb[in_rd] = 1'b1;
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic [CTRL_W-1:0] ctrl);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we; in_ctrl = ctrl;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_ex_zero(input string tag);
        check(tag, {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_we, ex_ctrl}, '0);
    endtask

    initial begin
        rst = 1'b1;
        ex_ready = 1'b1;
        drive(0, 0, 0, 0, 0, '0);
        wb(0, 0, 0);
        step(1);
        mon_en = 1'b1;
        step(1);
        rst = 1'b0;
        check_ex_zero("reset_ex");
        check("reset_sb", u_dut.u_sb.busy_o, 32'd0);

        // Basic fetch: x3, x4 into operands one cycle later
        drive(1, 3, 4, 0, 0, 16'h0101);
        step(1);
        drive(0, 0, 0, 0, 0, '0);
        check("t030_op", {ex_valid, ex_op_a, ex_op_b}, {1'b1, 32'h11, 32'h22});

        // RAW on x5 waits for writeback
        drive(1, 1, 2, 5, 1, 16'h0202);
        step(1);
        drive(1, 5, 0, 6, 0, 16'h0303);
        step(2);
        check("t031_stall", in_ready, 1'b0);
        wb(1, 5, 32'h0000_ABCD);
        step(1);
        wb(0, 0, 0);
`ifdef ID_WB_BYPASS_EN
        check("t031_byp_op_a", ex_op_a, 32'h0000_ABCD);
        drive(0, 0, 0, 0, 0, '0);
`else
        check("t031_ready_after_wb", in_ready, 1'b1);
        step(1);
        drive(0, 0, 0, 0, 0, '0);
        check("t031_op_a", ex_op_a, 32'h0000_ABCD);
`endif
        step(1);

        // x0 source with a writeback to x0: operand zero, bit 0 never set
        wb(1, 0, 32'hFFFF_FFFF);
        drive(1, 0, 0, 0, 1, 16'h0404);
        step(1);
        wb(0, 0, 0);
        drive(0, 0, 0, 0, 0, '0);
        check("t032_op", {ex_op_a, ex_op_b}, 64'd0);
        check("t032_bit0", u_dut.u_sb.busy_o[0], 1'b0);

        // Back-pressure hold for 3 cycles
        drive(1, 3, 4, 8, 0, 16'h0505);
        step(1);
        ex_ready = 1'b0;
        drive(1, 4, 3, 9, 0, 16'h0606);
        step(3);
        check("t033_hold", {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_we, ex_ctrl},
              {1'b1, 32'h11, 32'h22, 5'd8, 1'b0, 16'h0505});
        check("t033_ready", in_ready, 1'b0);
        ex_ready = 1'b1;
        step(1);
        drive(0, 0, 0, 0, 0, '0);
        step(1);

        // Set and clear of x7 in the same cycle: set wins; then WAW stall
        drive(1, 0, 0, 7, 1, 16'h0707);
        wb(1, 7, 32'h7777);
        step(1);
        wb(0, 0, 0);
        check("t034_bit7", u_dut.u_sb.busy_o[7], 1'b1);
        drive(1, 0, 0, 7, 1, 16'h0808);
        step(2);
        check("t034_waw", in_ready, 1'b0);
        wb(1, 7, 32'h7070);
        step(1);
        wb(0, 0, 0);
        step(1);
        drive(0, 0, 0, 0, 0, '0);
        check("t034_reissue", {ex_rd, ex_ctrl, u_dut.u_sb.busy_o[7]}, {5'd7, 16'h0808, 1'b1});
        wb(1, 7, 32'h7171);
        step(1);
        wb(0, 0, 0);

        // Random traffic with back-pressure and writebacks
        for (int c = 0; c < 80; c++) begin
            ex_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 16'($urandom));
            if (m_sb != 0 && $urandom_range(0, 1) == 1) begin
                for (int i = 1; i < 32; i++) begin
                    if (m_sb[i]) begin
                        wb(1, 5'(i), $urandom);
                        break;
                    end
                end
            end else begin
                wb($urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom);
            end
            step(1);
        end
        drive(0, 0, 0, 0, 0, '0);
        wb(0, 0, 0);
        ex_ready = 1'b1;
        for (int i = 1; i < 32; i++) begin
            if (m_sb[i]) begin
                wb(1, 5'(i), 32'h5A5A_0000 | i);
                step(1);
            end
        end
        wb(0, 0, 0);
        step(2);

        // Reset with a held instruction and x2, x9 busy
        drive(1, 0, 0, 2, 1, 16'h0909);
        step(1);
        drive(1, 0, 0, 9, 1, 16'h0A0A);
        step(1);
        drive(0, 0, 0, 0, 0, '0);
        ex_ready = 1'b0;
        step(1);
        check("t035_pre", {ex_valid, u_dut.u_sb.busy_o}, {1'b1, 32'h0000_0204});
        rst = 1'b1;
        wb(1, 2, 32'h2222);
        drive(1, 0, 0, 3, 1, 16'h0B0B);
        step(1);
        rst = 1'b0;
        wb(0, 0, 0);
        drive(0, 0, 0, 0, 0, '0);
        check_ex_zero("t035_ex");
        check("t035_sb", u_dut.u_sb.busy_o, 32'd0);

        ex_ready = 1'b1;
        step(3);
        check("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
